// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe: three-stage integer to IEEE-754-style float converter.
// Stage 1 takes the sign and magnitude, stage 2 normalises, stage 3 rounds
// to nearest even and packs. A full-pipeline stall is raised whenever the
// output holds a result that downstream is not accepting.
// Optional build macro I2F_INEXACT_EN adds the out_inexact flag port.
module int_to_float_pipe #(
  parameter int INT_W = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_int,
  input  logic                   in_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_flt
`ifdef I2F_INEXACT_EN
  ,
  output logic                   out_inexact
`endif
);

  localparam int PW  = $clog2(INT_W) + 1;
  localparam int EW2 = EXP_W + 2;
  localparam int XW  = INT_W + MAN_W + 1;

  logic stall;

  // Global stall: everything holds while the output is blocked
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall;
  end

  // ---------------- Stage 1: sign / magnitude ----------------
  logic             s1_valid;
  logic             s1_sign;
  logic [INT_W:0]   s1_mag;
  logic             s1_sign_d;
  logic [INT_W:0]   s1_ext;
  logic [INT_W:0]   s1_mag_d;

  // Magnitude is one bit wider so the most negative value negates exactly
  always_comb begin
    s1_sign_d = in_signed & in_int[INT_W-1];
    s1_ext    = {s1_sign_d, in_int};
    s1_mag_d  = s1_sign_d ? (~s1_ext + 1'b1) : s1_ext;
  end

  // Stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_sign  <= s1_sign_d;
      s1_mag   <= s1_mag_d;
    end
  end

  // ---------------- Stage 2: normalise ----------------
  logic             s2_valid;
  logic             s2_sign;
  logic             s2_zero;
  logic [INT_W-2:0] s2_frac;
  logic [EW2-1:0]   s2_exp;
  logic [PW-1:0]    lead;
  logic [PW-1:0]    shamt;
  logic [INT_W-2:0] frac_d;
  logic [EW2-1:0]   exp_d;
  logic             zero_d;

  // Leading-one search (highest set bit wins) and left shift; the leading
  // one itself is implicit, so only the bits below it are kept
  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < INT_W; i++) begin
      if (s1_mag[i]) lead = PW'(i);
    end
    shamt  = PW'(INT_W - 1) - lead;
    frac_d = (INT_W-1)'(s1_mag[INT_W-1:0] << shamt);
    exp_d  = EW2'(lead) + EW2'(BIAS);
    zero_d = (s1_mag == '0);
  end

  // Stage 2 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_frac  <= '0;
      s2_exp   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= zero_d;
      s2_frac  <= frac_d;
      s2_exp   <= exp_d;
    end
  end

  // ---------------- Stage 3: round / pack ----------------
  logic [XW-1:0]      xv;
  logic [MAN_W-1:0]   mant;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [MAN_W:0]     mant_r;
  logic [EW2-1:0]     exp_f;
  logic               ovf;
  logic [EXP_W+MAN_W:0] flt_d;

  // Zero padding below the fraction makes narrow integers convert exactly
  always_comb begin
    xv       = {s2_frac, {(MAN_W+2){1'b0}}};
    mant     = xv[XW-1 -: MAN_W];
    guard    = xv[XW-1-MAN_W];
    sticky   = |xv[XW-2-MAN_W:0];
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    exp_f    = s2_exp + EW2'(mant_r[MAN_W]);
    ovf      = (exp_f >= EW2'((2**EXP_W) - 1));
    if (s2_zero)
      flt_d = '0;
    else if (ovf)
      flt_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      flt_d = {s2_sign, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
  end

`ifdef I2F_INEXACT_EN
  logic inexact_d;

  // Inexact whenever bits were discarded or the value saturated to infinity
  always_comb begin
    inexact_d = ~s2_zero & (guard | sticky | ovf);
  end

  // Flag register, aligned with out_flt
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_inexact <= 1'b0;
    else if (!stall && s2_valid)
      out_inexact <= inexact_d;
  end
`endif

  // Output register; data only updates when a real item arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flt   <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) out_flt <= flt_d;
    end
  end

endmodule
